// File: rtl/pieo_post_deq_tx.sv
// Post-dequeue transmit controller for a PIEO scheduler.
// Requests one element from the PIEO, maps its fifo_id to that FIFO's
// head-packet length, streams ceil(len/8) beats to the MAC side under
// valid/ready backpressure, then pops the FIFO and reports completion.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   pieo_not_empty        PIEO holds an eligible element
//   pieo_deq_trigger      one-cycle dequeue request (only ever in IDLE)
//   pieo_deq_valid        pieo_deq_element valid (honoured in WAIT_ELEM only)
//   pieo_deq_element      {send_time, rank, fifo_id}; send_time is ignored
//   fifo_packet_length    head-packet length per FIFO, slice i at i*PKT_LEN_WIDTH
//   tx_valid/tx_ready     beat handshake to the MAC side
//   tx_fifo_id, tx_last   source FIFO of the beat, final-beat flag
//   fifo_pop              one-hot one-cycle pop of the finished FIFO
//   deq_done(_id/_rank)   one-cycle completion report to the enqueue tracker
//   err_timeout           one-cycle pulse, no element arrived in time
//   err_bad_id            one-cycle pulse, element fifo_id >= NUM_FIFO
module pieo_post_deq_tx #(
  parameter int unsigned NUM_FIFO      = 3,
  parameter int unsigned PKT_LEN_WIDTH = 16,
  parameter int unsigned ID_LOG        = 2,
  parameter int unsigned RANK_LOG      = 1,
  parameter int unsigned TIME_LOG      = 1,
  parameter int unsigned DEQ_TIMEOUT   = 15
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                pieo_not_empty,
  output logic                                pieo_deq_trigger,
  input  logic                                pieo_deq_valid,
  input  logic [ID_LOG+RANK_LOG+TIME_LOG-1:0] pieo_deq_element,
  input  logic [NUM_FIFO*PKT_LEN_WIDTH-1:0]   fifo_packet_length,
  output logic                                tx_valid,
  input  logic                                tx_ready,
  output logic [ID_LOG-1:0]                   tx_fifo_id,
  output logic                                tx_last,
  output logic [NUM_FIFO-1:0]                 fifo_pop,
  output logic                                deq_done,
  output logic [ID_LOG-1:0]                   deq_done_id,
  output logic [RANK_LOG-1:0]                 deq_done_rank,
  output logic                                err_timeout,
  output logic                                err_bad_id
);

  localparam int unsigned ELEM_W = ID_LOG + RANK_LOG + TIME_LOG;
  localparam int unsigned CNT_W  = PKT_LEN_WIDTH + 1;
  localparam int unsigned WAIT_W = (DEQ_TIMEOUT > 1) ? $clog2(DEQ_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_ELEM, XMIT, DONE} state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]    beat_q, beat_d;
  logic [ID_LOG-1:0]   id_q, id_d;
  logic [RANK_LOG-1:0] rank_q, rank_d;

  logic                trig_d, tx_valid_d, tx_last_d, done_d, err_to_d, err_bad_d;
  logic [ID_LOG-1:0]   tx_id_d, done_id_d;
  logic [RANK_LOG-1:0] done_rank_d;
  logic [NUM_FIFO-1:0] pop_d;

  // Element field split; send_time is deliberately dropped.
  logic [ID_LOG-1:0]        elem_id;
  logic [RANK_LOG-1:0]      elem_rank;
  logic                     elem_bad;
  logic                     unused_send_time;
  logic [PKT_LEN_WIDTH-1:0] sel_len;
  logic [CNT_W-1:0]         elem_beats;

  assign elem_id          = pieo_deq_element[ID_LOG-1:0];
  assign elem_rank        = pieo_deq_element[ID_LOG +: RANK_LOG];
  assign unused_send_time = ^pieo_deq_element[ELEM_W-1 -: TIME_LOG];
  // 32-bit compare so NUM_FIFO == 2**ID_LOG does not wrap to zero.
  assign elem_bad         = 32'(elem_id) >= NUM_FIFO;

  // Head-packet length of the FIFO named by the incoming element.
  always_comb begin
    sel_len = '0;
    for (int unsigned i = 0; i < NUM_FIFO; i++) begin
      if (32'(elem_id) == i) sel_len = fifo_packet_length[i*PKT_LEN_WIDTH +: PKT_LEN_WIDTH];
    end
  end

  // ceil(len/8) with one extra bit so the maximum length cannot overflow.
  assign elem_beats = (CNT_W'(sel_len) + CNT_W'(7)) >> 3;

  // Next state and next registered output values.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    beat_d    = beat_q;
    id_d      = id_q;
    rank_d    = rank_q;
    err_to_d  = 1'b0;
    err_bad_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (pieo_deq_trigger) begin
          state_d = WAIT_ELEM;
          wait_d  = '0;
        end
      end
      WAIT_ELEM: begin
        // A valid element in the final wait cycle beats the timeout.
        if (pieo_deq_valid) begin
          if (elem_bad) begin
            err_bad_d = 1'b1;
            state_d   = IDLE;
          end else begin
            id_d    = elem_id;
            rank_d  = elem_rank;
            beat_d  = elem_beats;
            state_d = (elem_beats == '0) ? DONE : XMIT;
          end
        end else if (wait_q == WAIT_W'(DEQ_TIMEOUT - 1)) begin
          err_to_d = 1'b1;
          state_d  = IDLE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      XMIT: begin
        if (tx_valid && tx_ready) begin
          beat_d = beat_q - CNT_W'(1);
          if (beat_q == CNT_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they align with it;
    // the trigger can therefore only be seen while the FSM sits in IDLE.
    trig_d      = (state_d == IDLE) && pieo_not_empty;
    tx_valid_d  = (state_d == XMIT);
    tx_id_d     = (state_d == XMIT) ? id_d : '0;
    tx_last_d   = (state_d == XMIT) && (beat_d == CNT_W'(1));
    done_d      = (state_d == DONE);
    pop_d       = done_d ? (NUM_FIFO'(1) << id_d) : '0;
    done_id_d   = done_d ? id_d : '0;
    done_rank_d = done_d ? rank_d : '0;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      wait_q           <= '0;
      beat_q           <= '0;
      id_q             <= '0;
      rank_q           <= '0;
      pieo_deq_trigger <= 1'b0;
      tx_valid         <= 1'b0;
      tx_fifo_id       <= '0;
      tx_last          <= 1'b0;
      fifo_pop         <= '0;
      deq_done         <= 1'b0;
      deq_done_id      <= '0;
      deq_done_rank    <= '0;
      err_timeout      <= 1'b0;
      err_bad_id       <= 1'b0;
    end else begin
      state_q          <= state_d;
      wait_q           <= wait_d;
      beat_q           <= beat_d;
      id_q             <= id_d;
      rank_q           <= rank_d;
      pieo_deq_trigger <= trig_d;
      tx_valid         <= tx_valid_d;
      tx_fifo_id       <= tx_id_d;
      tx_last          <= tx_last_d;
      fifo_pop         <= pop_d;
      deq_done         <= done_d;
      deq_done_id      <= done_id_d;
      deq_done_rank    <= done_rank_d;
      err_timeout      <= err_to_d;
      err_bad_id       <= err_bad_d;
    end
  end

endmodule

// File: tb/tb_pieo_post_deq_tx.sv
// Directed bench for pieo_post_deq_tx: expected packets are queued when an
// element is handed to the DUT and checked when the DUT reports completion.
module tb_pieo_post_deq_tx;

  localparam int unsigned NUM_FIFO = 3;
  localparam int unsigned PLW      = 16;
  localparam int unsigned ID_LOG   = 2;
  localparam int unsigned RANK_LOG = 1;
  localparam int unsigned TIME_LOG = 1;
  localparam int unsigned ELEM_W   = ID_LOG + RANK_LOG + TIME_LOG;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      pieo_not_empty;
  logic                      pieo_deq_trigger;
  logic                      pieo_deq_valid;
  logic [ELEM_W-1:0]         pieo_deq_element;
  logic [NUM_FIFO*PLW-1:0]   fifo_packet_length;
  logic                      tx_valid;
  logic                      tx_ready;
  logic [ID_LOG-1:0]         tx_fifo_id;
  logic                      tx_last;
  logic [NUM_FIFO-1:0]       fifo_pop;
  logic                      deq_done;
  logic [ID_LOG-1:0]         deq_done_id;
  logic [RANK_LOG-1:0]       deq_done_rank;
  logic                      err_timeout;
  logic                      err_bad_id;

  pieo_post_deq_tx dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .pieo_not_empty     (pieo_not_empty),
    .pieo_deq_trigger   (pieo_deq_trigger),
    .pieo_deq_valid     (pieo_deq_valid),
    .pieo_deq_element   (pieo_deq_element),
    .fifo_packet_length (fifo_packet_length),
    .tx_valid           (tx_valid),
    .tx_ready           (tx_ready),
    .tx_fifo_id         (tx_fifo_id),
    .tx_last            (tx_last),
    .fifo_pop           (fifo_pop),
    .deq_done           (deq_done),
    .deq_done_id        (deq_done_id),
    .deq_done_rank      (deq_done_rank),
    .err_timeout        (err_timeout),
    .err_bad_id         (err_bad_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int rank;
    int beats;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] outs();
    return {pieo_deq_trigger, tx_valid, tx_fifo_id, tx_last, fifo_pop,
            deq_done, deq_done_id, deq_done_rank, err_timeout, err_bad_id};
  endfunction

  function automatic logic [ELEM_W-1:0] mk_elem(input int id, input int rank);
    logic [TIME_LOG-1:0] st;
    st = TIME_LOG'($urandom_range(1, 0));
    return {st, RANK_LOG'(rank), ID_LOG'(id)};
  endfunction

  task automatic set_len(input int id, input int len);
    fifo_packet_length[id*PLW +: PLW] = PLW'(len);
  endtask

  task automatic wait_trig(input string tag, output bit got);
    int n;
    n = 0;
    while (pieo_deq_trigger !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    got = (pieo_deq_trigger === 1'b1);
    chk({tag, "_trigger"}, 64'(pieo_deq_trigger), 64'(1));
  endtask

  // One full dequeue: trigger, element after 'delay' cycles, stream, done.
  task automatic do_elem(input string tag, input int id, input int rank, input int delay,
                         input bit toggle, input bit spurious);
    bit   got, done, stalled;
    int   beats, k, acc, done_k, id_err, last_err, drop_err, err_pulse, budget;
    exp_t e;
    beats  = (int'(fifo_packet_length[id*PLW +: PLW]) + 7) / 8;
    budget = 2 * beats + 40;
    done = 1'b0; stalled = 1'b0;
    k = 0; acc = 0; done_k = 0; id_err = 0; last_err = 0; drop_err = 0; err_pulse = 0;

    pieo_not_empty = 1'b1;
    wait_trig(tag, got);
    pieo_not_empty = 1'b0;
    if (!got) return;
    step();
    chk({tag, "_trigger_one_cycle"}, 64'(pieo_deq_trigger), 64'(0));
    for (int i = 1; i < delay; i++) step();
    pieo_deq_valid   = 1'b1;
    pieo_deq_element = mk_elem(id, rank);
    sb.push_back('{id: id, rank: rank, beats: beats});
    step();
    // Optionally keep a bad element valid during XMIT; it must be ignored.
    if (spurious) pieo_deq_element = mk_elem(int'(NUM_FIFO), 0);
    else          pieo_deq_valid   = 1'b0;

    while (!done && k < budget) begin
      k++;
      if (err_timeout !== 1'b0 || err_bad_id !== 1'b0) err_pulse++;
      if (stalled && tx_valid !== 1'b1) drop_err++;
      if (tx_valid === 1'b1 && tx_fifo_id !== ID_LOG'(id)) id_err++;
      if (deq_done === 1'b1) begin
        done   = 1'b1;
        done_k = k;
        chk({tag, "_sb_depth"}, 64'(sb.size()), 64'(1));
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk({tag, "_done_id"}, 64'(deq_done_id), 64'(e.id));
          chk({tag, "_done_rank"}, 64'(deq_done_rank), 64'(e.rank));
          chk({tag, "_fifo_pop"}, 64'(fifo_pop), 64'(1) << e.id);
          chk({tag, "_beats"}, 64'(acc), 64'(e.beats));
        end
      end
      tx_ready = toggle ? (k % 2 == 1) : 1'b1;
      stalled  = (tx_valid === 1'b1) && !tx_ready;
      if (tx_valid === 1'b1 && tx_ready) begin
        acc++;
        if (tx_last !== (acc == beats)) last_err++;
      end
      step();
    end

    chk({tag, "_done_seen"}, 64'(done), 64'(1));
    chk({tag, "_done_single"}, 64'({deq_done, fifo_pop}), 64'(0));
    chk({tag, "_tx_id_stable"}, 64'(id_err), 64'(0));
    chk({tag, "_tx_last"}, 64'(last_err), 64'(0));
    chk({tag, "_no_drop"}, 64'(drop_err), 64'(0));
    chk({tag, "_no_err"}, 64'(err_pulse), 64'(0));
    if (!toggle) chk({tag, "_latency"}, 64'(done_k), 64'(beats + 1));
    pieo_deq_valid = 1'b0;
    tx_ready       = 1'b0;
  endtask

  initial begin
    bit got;
    int off, acc, n, q;

    rst_n = 1'b0; pieo_not_empty = 1'b0; pieo_deq_valid = 1'b0;
    pieo_deq_element = '0; tx_ready = 1'b0; fifo_packet_length = '0;
    set_len(0, 0);
    set_len(1, 64);
    set_len(2, 65);
    repeat (3) step();
    chk("reset_outs", 64'(outs()), 64'(0));

    // Trigger visible in the first cycle after reset release.
    rst_n = 1'b1;
    pieo_not_empty = 1'b1;
    step();
    chk("first_trigger", 64'(pieo_deq_trigger), 64'(1));

    do_elem("len64", 1, 1, 2, 1'b0, 1'b0);
    do_elem("len65_bp", 2, 0, 3, 1'b1, 1'b1);

    // Bad fifo_id: error pulse, no pop, immediate retrigger.
    pieo_not_empty = 1'b1;
    wait_trig("badid", got);
    step();
    step();
    pieo_deq_valid = 1'b1;
    pieo_deq_element = mk_elem(3, 1);
    step();
    pieo_deq_valid = 1'b0;
    chk("badid_err", 64'(err_bad_id), 64'(1));
    chk("badid_no_pop", 64'({fifo_pop, deq_done, tx_valid}), 64'(0));
    chk("badid_retrigger", 64'(pieo_deq_trigger), 64'(1));
    pieo_not_empty = 1'b0;
    step();
    chk("badid_one_cycle", 64'(err_bad_id), 64'(0));

    // That retrigger gets no element: timeout decided 15 cycles after it.
    off = 1;
    while (err_timeout !== 1'b1 && off < 40) begin
      step();
      off++;
    end
    chk("timeout_cycle", 64'(off), 64'(16));
    chk("timeout_quiet", 64'({fifo_pop, deq_done, tx_valid, err_bad_id}), 64'(0));
    step();
    chk("timeout_one_cycle", 64'(err_timeout), 64'(0));

    set_len(0, 8);
    do_elem("valid_cyc15", 0, 1, 15, 1'b0, 1'b0);
    set_len(0, 0);
    do_elem("len0", 0, 0, 2, 1'b0, 1'b0);
    set_len(1, 16'hFFFF);
    do_elem("lenmax", 1, 1, 2, 1'b0, 1'b0);

    // Reset during beat 3 of 8 abandons the packet.
    set_len(2, 64);
    pieo_not_empty = 1'b1;
    wait_trig("rst_mid", got);
    pieo_not_empty = 1'b0;
    step();
    step();
    pieo_deq_valid = 1'b1;
    pieo_deq_element = mk_elem(2, 1);
    step();
    pieo_deq_valid = 1'b0;
    tx_ready = 1'b1;
    acc = 0;
    n = 0;
    while (acc < 2 && n < 20) begin
      if (tx_valid === 1'b1) acc++;
      step();
      n++;
    end
    chk("rst_mid_beat3", 64'({tx_valid, tx_last}), 64'(2));
    rst_n = 1'b0;
    step();
    chk("rst_mid_outs", 64'(outs()), 64'(0));
    step();
    chk("rst_hold_outs", 64'(outs()), 64'(0));
    rst_n = 1'b1;
    tx_ready = 1'b0;
    q = 0;
    for (int i = 0; i < 6; i++) begin
      if (deq_done !== 1'b0 || fifo_pop !== '0 || tx_valid !== 1'b0) q++;
      step();
    end
    chk("rst_abandoned_quiet", 64'(q), 64'(0));
    do_elem("after_rst", 2, 1, 2, 1'b0, 1'b0);

    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: observed no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pieo_post_deq_tx.md
PIEO_POST_DEQ_TX -- requirements
Module: pieo_post_deq_tx

Interface
REQ-001 SHALL have parameter NUM_FIFO, default 3, number of per-flow FIFOs.
REQ-002 SHALL have parameter PKT_LEN_WIDTH, default 16, packet-length width in bytes.
REQ-003 SHALL have parameters ID_LOG=2, RANK_LOG=1, TIME_LOG=1, field widths of a PIEO element {send_time, rank, fifo_id}, fifo_id in the LSBs.
REQ-004 SHALL have parameter DEQ_TIMEOUT, default 15, max cycles to wait for a dequeued element.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 pieo_not_empty  in  1  PIEO holds at least one eligible element.
REQ-008 pieo_deq_trigger  out  1  one-cycle dequeue request to PIEO.
REQ-009 pieo_deq_valid  in  1  pieo_deq_element valid this cycle.
REQ-010 pieo_deq_element  in  ID_LOG+RANK_LOG+TIME_LOG  dequeued element.
REQ-011 fifo_packet_length  in  NUM_FIFO*PKT_LEN_WIDTH  head-packet length per FIFO, slice i at i*PKT_LEN_WIDTH.
REQ-012 tx_valid  out  1  beat available to MAC side.
REQ-013 tx_ready  in  1  MAC side accepts beat.
REQ-014 tx_fifo_id  out  ID_LOG  FIFO sourcing current beat.
REQ-015 tx_last  out  1  current beat is final beat of packet.
REQ-016 fifo_pop  out  NUM_FIFO  one-hot one-cycle pop of head packet.
REQ-017 deq_done  out  1  one-cycle pulse, packet finished; to enq fifo tracker.
REQ-018 deq_done_id  out  ID_LOG  FIFO id accompanying deq_done.
REQ-019 deq_done_rank  out  RANK_LOG  rank of completed element.
REQ-020 err_timeout  out  1  one-cycle pulse, dequeue timed out.
REQ-021 err_bad_id  out  1  one-cycle pulse, element fifo_id >= NUM_FIFO.

Function
REQ-022 SHALL implement FSM states IDLE, WAIT_ELEM, XMIT, DONE.
REQ-023 IDLE: if pieo_not_empty=1, SHALL assert pieo_deq_trigger for exactly one cycle and enter WAIT_ELEM next cycle; else stay.
REQ-024 WAIT_ELEM: SHALL count cycles from 0; pieo_deq_valid accepted only here; valid in other states ignored.
REQ-025 WAIT_ELEM, valid with fifo_id >= NUM_FIFO: SHALL pulse err_bad_id, no pop, no done, return to IDLE.
REQ-026 WAIT_ELEM, valid with good id: SHALL latch fifo_id and rank, load beat counter with ceil(len/8) of that FIFO's length (computed in PKT_LEN_WIDTH+1 bits, no overflow at max length), enter XMIT.
REQ-027 Length 0: SHALL skip XMIT, go directly to DONE.
REQ-028 Timeout: counter reaching DEQ_TIMEOUT without valid SHALL pulse err_timeout and return to IDLE; valid on the same cycle wins over timeout.
REQ-029 XMIT: tx_valid=1, tx_fifo_id = latched id; counter decrements on tx_valid&tx_ready; tx_last=1 when counter==1; accepted last beat enters DONE.
REQ-030 tx_valid SHALL stay high with stable tx_fifo_id until the beat is accepted (no drop under backpressure).
REQ-031 DONE: SHALL pulse fifo_pop[id], deq_done, deq_done_id, deq_done_rank in one cycle, then IDLE.
REQ-032 Minimum gap SHALL be: trigger cycle, >=1 WAIT_ELEM cycle, beats, DONE; a new trigger no earlier than the cycle after DONE.
REQ-033 pieo_deq_trigger SHALL never assert outside IDLE; at most one element outstanding.
REQ-034 Send_time field SHALL be ignored.

Reset
REQ-035 rst_n=0 at any clock edge SHALL force IDLE, clear counters and latched id/rank, drive all outputs 0 next cycle, including mid-XMIT (partial packet abandoned, no pop, no done).
REQ-036 First trigger SHALL be possible the first cycle after rst_n rises.

Verification
REQ-037 len[1]=64, element id=1 rank=1 valid 2 cycles after trigger, tx_ready=1 -> 8 beats, tx_last on 8th, fifo_pop=3'b010, deq_done_id=1, deq_done_rank=1.
REQ-038 len=65, tx_ready toggling 1/0 -> 9 beats accepted, tx_fifo_id stable while stalled, single done.
REQ-039 element id=3 with NUM_FIFO=3 -> err_bad_id pulse, fifo_pop=0, back to IDLE, retrigger next cycle if not empty.
REQ-040 No valid for 15 cycles after trigger -> err_timeout on cycle 15; valid on cycle 15 -> accepted, no error.
REQ-041 len=0 for id=0 -> no tx_valid, deq_done next cycle after valid; len=16'hFFFF -> 8192 beats.
REQ-042 rst_n low during beat 3 of 8 -> all outputs 0, no pop/done; restart completes next packet normally.
